// File: rtl/bound_flasher_pkg.sv
// Shared constants and state encoding for the bound flasher blocks.
package bound_flasher_pkg;

  typedef enum logic [2:0] {
    ST_INITIAL  = 3'd0,
    ST_ON_0_5   = 3'd1,
    ST_OFF_5_0  = 3'd2,
    ST_ON_0_10  = 3'd3,
    ST_OFF_10_5 = 3'd4,
    ST_ON_5_15  = 3'd5,
    ST_OFF_15_0 = 3'd6,
    ST_ILLEGAL  = 3'd7
  } flasher_st_t;

  localparam int unsigned N_LAMP_DEFAULT = 16;

  // Lit-lamp counts at which lamps 5, 10 and 15 become the highest lit lamp.
  localparam int unsigned CNT_B5  = 6;
  localparam int unsigned CNT_B10 = 11;
  localparam int unsigned CNT_B15 = 16;

endpackage

// File: rtl/lamp_boundary_decode.sv
// Combinational decode of the lit-lamp count into the boundary flags
// consumed by the flasher next-state logic.
module lamp_boundary_decode
  import bound_flasher_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic [CNT_W-1:0] lit_cnt,
  output logic             reach_off,
  output logic             reach_5,
  output logic             reach_10,
  output logic             reach_15
);

  always_comb begin
    reach_off = (lit_cnt == '0);
    reach_5   = (lit_cnt == CNT_W'(CNT_B5));
    reach_10  = (lit_cnt == CNT_W'(CNT_B10));
    reach_15  = (lit_cnt == CNT_W'(CNT_B15));
  end

endmodule

// File: rtl/lamp_shift_driver.sv
// Thermometer lamp driver: fills in ON states, drains in OFF states.
// Optional state/invariant checking enabled by LAMP_DRIVER_STATE_CHECK_EN.
module lamp_shift_driver
  import bound_flasher_pkg::*;
#(
  parameter int unsigned N_LAMP = N_LAMP_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(N_LAMP + 1)
) (
  input  logic              div_clk,
  input  logic              rst,
  input  logic [2:0]        cur_st,
  output logic [N_LAMP-1:0] lamp,
  output logic [CNT_W-1:0]  lit_cnt,
  output logic              reach_off,
  output logic              reach_5,
  output logic              reach_10,
  output logic              reach_15,
  output logic              st_err
);

  flasher_st_t st;
  assign st = flasher_st_t'(cur_st);

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      lamp    <= '0;
      lit_cnt <= '0;
    end else begin
      case (st)
        ST_INITIAL: begin
          lamp    <= '0;
          lit_cnt <= '0;
        end
        ST_ON_0_5, ST_ON_0_10, ST_ON_5_15: begin
          if (lit_cnt < CNT_W'(N_LAMP)) begin
            lamp    <= {lamp[N_LAMP-2:0], 1'b1};
            lit_cnt <= lit_cnt + 1'b1;
          end
        end
        ST_OFF_5_0, ST_OFF_10_5, ST_OFF_15_0: begin
          if (lit_cnt != '0) begin
            lamp    <= lamp >> 1;
            lit_cnt <= lit_cnt - 1'b1;
          end
        end
        default: begin
          lamp    <= lamp;
          lit_cnt <= lit_cnt;
        end
      endcase
    end
  end

  lamp_boundary_decode #(
    .CNT_W(CNT_W)
  ) u_decode (
    .lit_cnt  (lit_cnt),
    .reach_off(reach_off),
    .reach_5  (reach_5),
    .reach_10 (reach_10),
    .reach_15 (reach_15)
  );

`ifdef LAMP_DRIVER_STATE_CHECK_EN
  localparam logic [N_LAMP-1:0] ONE = N_LAMP'(1);

  // Shift overflows to zero at full count, so the subtraction still yields all ones.
  logic [N_LAMP-1:0] therm;
  assign therm = (ONE << lit_cnt) - ONE;

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      st_err <= 1'b0;
    end else if ((st == ST_ILLEGAL) || (lamp != therm)) begin
      st_err <= 1'b1;
    end
  end
`else
  assign st_err = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_shift_driver.sv
// Randomized self-checking bench for lamp_shift_driver against a count-based model.
module tb_lamp_shift_driver;

  logic        div_clk = 1'b0;
  logic        rst;
  logic [2:0]  cur_st;
  logic [15:0] lamp;
  logic [4:0]  lit_cnt;
  logic        reach_off, reach_5, reach_10, reach_15, st_err;

  int n_checks = 0;
  int n_err    = 0;
  int m_cnt;
  bit m_err;

  always #5 div_clk = ~div_clk;

  lamp_shift_driver #(
    .N_LAMP(16),
    .CNT_W (5)
  ) dut (
    .div_clk  (div_clk),
    .rst      (rst),
    .cur_st   (cur_st),
    .lamp     (lamp),
    .lit_cnt  (lit_cnt),
    .reach_off(reach_off),
    .reach_5  (reach_5),
    .reach_10 (reach_10),
    .reach_15 (reach_15),
    .st_err   (st_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_lamp(input int cnt);
    return ((32'h1 << cnt) - 32'h1) & 32'h0000_FFFF;
  endfunction

  function automatic bit exp_st_err();
`ifdef LAMP_DRIVER_STATE_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string pfx);
    check_eq({pfx, ".lamp"},      32'(lamp),      exp_lamp(m_cnt));
    check_eq({pfx, ".lit_cnt"},   32'(lit_cnt),   32'(m_cnt));
    check_eq({pfx, ".reach_off"}, 32'(reach_off), 32'(m_cnt == 0));
    check_eq({pfx, ".reach_5"},   32'(reach_5),   32'(m_cnt == 6));
    check_eq({pfx, ".reach_10"},  32'(reach_10),  32'(m_cnt == 11));
    check_eq({pfx, ".reach_15"},  32'(reach_15),  32'(m_cnt == 16));
    check_eq({pfx, ".st_err"},    32'(st_err),    32'(exp_st_err()));
  endtask

  // Called at a negedge: drive state, take one edge, update model, check at next negedge.
  task automatic step(input logic [2:0] st, input string pfx);
    cur_st = st;
    @(posedge div_clk);
    case (st)
      3'd0:             m_cnt = 0;
      3'd1, 3'd3, 3'd5: if (m_cnt < 16) m_cnt++;
      3'd2, 3'd4, 3'd6: if (m_cnt > 0) m_cnt--;
      default:          m_err = 1'b1;
    endcase
    @(negedge div_clk);
    check_all(pfx);
  endtask

  task automatic steps(input logic [2:0] st, input int n, input string pfx);
    for (int i = 0; i < n; i++) step(st, pfx);
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic async_reset(input string pfx);
    #2 rst = 1'b1;
    m_cnt = 0;
    m_err = 1'b0;
    #1 check_all(pfx);
    @(negedge div_clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    cur_st = 3'd0;
    m_cnt  = 0;
    m_err  = 1'b0;
    repeat (2) @(negedge div_clk);
    check_all("reset");
    rst = 1'b0;

    steps(3'd1, 6, "fill5");
    check_eq("fill5.lamp_abs", 32'(lamp), 32'h003F);
    check_eq("fill5.reach_5_abs", 32'(reach_5), 32'h1);

    steps(3'd2, 6, "drain0");
    check_eq("drain0.lamp_abs", 32'(lamp), 32'h0);
    step(3'd2, "drain_sat");
    check_eq("drain_sat.lamp_abs", 32'(lamp), 32'h0);

    steps(3'd3, 11, "fill10");
    check_eq("fill10.lamp_abs", 32'(lamp), 32'h07FF);
    steps(3'd4, 5, "drain5");
    check_eq("drain5.lamp_abs", 32'(lamp), 32'h003F);
    steps(3'd5, 10, "fill15");
    check_eq("fill15.lamp_abs", 32'(lamp), 32'hFFFF);
    step(3'd5, "fill_sat");
    check_eq("fill_sat.lamp_abs", 32'(lamp), 32'hFFFF);

    step(3'd0, "init_clear");
    check_eq("init_clear.lamp_abs", 32'(lamp), 32'h0);

    steps(3'd3, 9, "rev_pre");
    check_eq("rev_pre.lamp_abs", 32'(lamp), 32'h01FF);
    step(3'd2, "rev");
    check_eq("rev.lamp_abs", 32'(lamp), 32'h00FF);

    steps(3'd3, 4, "to_0fff");
    check_eq("to_0fff.lamp_abs", 32'(lamp), 32'h0FFF);
    cur_st = 3'd3;
    async_reset("async_rst");
    check_eq("async_rst.lamp_abs", 32'(lamp), 32'h0);

    steps(3'd1, 3, "to_0007");
    step(3'd7, "illegal");
    check_eq("illegal.lamp_abs", 32'(lamp), 32'h0007);
    steps(3'd6, 2, "after_illegal");
    cur_st = 3'd0;
    async_reset("err_clear");

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset("rand_rst");
      end else if (r < 5) begin
        step(3'd0, "rand");
      end else if (r < 7) begin
        step(3'd7, "rand");
      end else begin
        step(3'($urandom_range(1, 6)), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lamp_shift_driver.md
# lamp_shift_driver

Output stage of the bound flasher, directly downstream of the state register. Consumes the registered current state `cur_st` and advances a 16-lamp thermometer register by one lamp per `div_clk` edge: it fills from the bottom in ON states and drains from the top in OFF states. It drives the lamp outputs and feeds boundary flags back to the next-state logic.

## Interface
- `N_LAMP`, default 16: number of lamps. Legal range 16..31.
- `CNT_W`, default `$clog2(N_LAMP+1)`: width of the lit-lamp count.
- `div_clk`, input, 1: divided system clock; all state updates on its rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `cur_st`, input, 3: current flasher state, taken from the state register.
- `lamp`, output, `N_LAMP`: lamp drive; bit i lights lamp i.
- `lit_cnt`, output, `CNT_W`: number of lit lamps.
- `reach_off`, output, 1: `lit_cnt == 0`.
- `reach_5`, output, 1: lamp 5 is the highest lit lamp (`lit_cnt == 6`).
- `reach_10`, output, 1: lamp 10 is the highest lit lamp (`lit_cnt == 11`).
- `reach_15`, output, 1: lamp 15 is the highest lit lamp (`lit_cnt == 16`).
- `st_err`, output, 1: sticky flag for an illegal state (see Configuration).

## Operation
- State codes:
  - 0 INITIAL
  - 1 ON_0_5
  - 2 OFF_5_0
  - 3 ON_0_10
  - 4 OFF_10_5
  - 5 ON_5_15
  - 6 OFF_15_0
  - 7 illegal
- Registers: `lamp` and `lit_cnt` only. All flags decode combinationally from `lit_cnt`.
- INITIAL: `lamp <= 0` and `lit_cnt <= 0` in a single edge, whatever the previous contents.
- ON states (1, 3, 5):
  - If `lit_cnt < N_LAMP`: `lamp <= {lamp[N_LAMP-2:0], 1'b1}` and `lit_cnt <= lit_cnt + 1`.
  - Otherwise hold (saturate at full).
- OFF states (2, 4, 6):
  - If `lit_cnt > 0`: `lamp <= lamp >> 1` and `lit_cnt <= lit_cnt - 1`.
  - Otherwise hold (saturate at empty).
- Illegal state 7: hold `lamp` and `lit_cnt`.
- The driver does not stop at a boundary on its own. The next-state logic must change `cur_st` when it sees a `reach_*` flag. If it does not, the driver keeps stepping until it saturates.
- Invariant, which must hold every cycle: `lamp == (1 << lit_cnt) - 1`, i.e. `lamp` is always a thermometer code.
- Direction reversal (e.g. OFF_10_5 → ON_5_15, or a flick kickback to an OFF state) takes effect on the first edge that sees the new `cur_st`. There is no idle cycle.

## Timing
- Reset values: `lamp = 0`, `lit_cnt = 0`, `reach_off = 1`, `reach_5 = 0`, `reach_10 = 0`, `reach_15 = 0`, `st_err = 0`.
- `rst` dominates every other input. Asserting it mid-sweep clears everything immediately, without waiting for a clock edge.
- `cur_st` changes just after edge k. The driver samples it at edge k+1, and `lamp` and the flags update at k+1.
- The flags are valid in the same cycle as the `lamp` value they describe. The next-state logic therefore sees `reach_5` during the cycle in which lamp 5 is lit, and the state register switches at the following edge.
- Throughput: one lamp per `div_clk` edge.
- A full fill from empty takes `N_LAMP` edges. A full drain takes `N_LAMP` edges.

## Configuration
- Macro: `LAMP_DRIVER_STATE_CHECK_EN`.
- Defined:
  - `st_err` is set on the first edge that samples `cur_st == 7`, and stays set until `rst`.
  - `st_err` is also set if the thermometer invariant is ever violated. This check is compiled in as an RTL comparison.
- Undefined:
  - `st_err` is tied to 0 and no checking logic is generated.
  - State 7 still holds `lamp` and `lit_cnt`.

## Structure
- The shared package `bound_flasher_pkg` holds:
  - the state localparams `ST_INITIAL` … `ST_OFF_15_0` and `ST_ILLEGAL`;
  - the default `N_LAMP`;
  - the boundary count constants `CNT_B5 = 6`, `CNT_B10 = 11`, `CNT_B15 = 16`.
- The state register and the next-state logic import the same package.
- Sub-module `lamp_boundary_decode`: purely combinational, mapping `lit_cnt` to `reach_off`, `reach_5`, `reach_10` and `reach_15`. It is reused by the next-state logic's assertion bench.

## Test plan
- Reset, release, then `cur_st = 1` for 6 edges → `lamp = 16'h003F`, `lit_cnt = 6`, `reach_5 = 1`, `reach_off = 0`.
- From `16'h003F`, `cur_st = 2` for 6 edges → `lamp = 0`, `reach_off = 1`. A 7th edge keeps `lamp = 0` (saturation).
- From 0, `cur_st = 3` for 11 edges → `16'h07FF`, `reach_10 = 1`. Then `cur_st = 4` for 5 edges → `16'h003F`, `reach_5 = 1`. Then `cur_st = 5` for 10 edges → `16'hFFFF`, `reach_15 = 1`. A further ON edge holds `16'hFFFF`.
- At `lamp = 16'h01FF` (`cur_st = 3`), switch to `cur_st = 2` → the next edge gives `16'h00FF`: immediate reversal with no idle cycle.
- Assert `rst` asynchronously mid-sweep at `16'h0FFF` → `lamp = 0`, `lit_cnt = 0`, `reach_off = 1` before the next edge. `cur_st = 0` at `16'hFFFF` → 0 in one edge.
- With `LAMP_DRIVER_STATE_CHECK_EN` defined, drive `cur_st = 7` for 1 edge at `16'h0007` → `lamp` holds `16'h0007` and `st_err = 1` stays set until `rst`. Without the macro, `st_err` stays 0 and `lamp` still holds.
